// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and the bit-vote helper.
// The transmitter imports this package too, so keep it free of receiver-only items.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_uart_cfg_if.sv
// Line, tick, configuration and result bundle of the configurable UART receiver.
interface rx_uart_cfg_if #(parameter int DATA_BITS = 8);

    logic                 i_rx;
    logic                 i_s_tick;
    logic [1:0]           i_parity_mode;
    logic                 i_two_stop;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_valid;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_break;
    logic                 o_busy;

    modport slave (
        input  i_rx, i_s_tick, i_parity_mode, i_two_stop,
        output o_data, o_valid, o_parity_err, o_frame_err, o_break, o_busy
    );

    modport master (
        output i_rx, i_s_tick, i_parity_mode, i_two_stop,
        input  o_data, o_valid, o_parity_err, o_frame_err, o_break, o_busy
    );

endinterface

// File: rtl/sync_edge.sv
// Synchroniser for the asynchronous rx line plus a falling-edge detector on the clean copy.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rx_s,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // Reset to 1 so an idle line never looks like a start bit coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
            prev  <= 1'b1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign rx_s       = chain[SYNC_STAGES-1];
    assign fall_pulse = prev & ~rx_s;

endmodule

// File: rtl/rx_uart_cfg.sv
// Configurable UART receiver. IDLE: wait for edge | START: verify start centre |
// DATA: payload bits | PARITY: optional parity bit | STOP1/STOP2: stop bit checks.
module rx_uart_cfg
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int TICKS       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          i_clock,
    input  logic          i_reset,
    rx_uart_cfg_if.slave  bus
);

    localparam int TW = $clog2(TICKS);
    localparam int BW = $clog2(DATA_BITS);

    uart_state_t          state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp0, samp1;
    logic [1:0]           par_mode;
    logic                 two_stop;
    logic                 perr, ferr, par_low, stop1_low;
    logic                 rx_s, fall_pulse;

    logic bit_end, bit_val, par_en, finishing, ferr_n, stop1_low_n, break_n;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (i_clock),
        .rst        (i_reset),
        .din        (bus.i_rx),
        .rx_s       (rx_s),
        .fall_pulse (fall_pulse)
    );

    assign bit_end     = bus.i_s_tick && (tick_cnt == TW'(TICKS-1));
    assign bit_val     = majority3(samp0, samp1, rx_s);
    assign par_en      = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
    assign finishing   = bit_end && ((state == STOP2) || (state == STOP1 && !two_stop));
    // Frame status as it will stand once the current (final) stop bit is folded in.
    assign ferr_n      = ((state == STOP2) ? ferr : 1'b0) | ~bit_val;
    assign stop1_low_n = (state == STOP1) ? ~bit_val : stop1_low;
    assign break_n     = (shreg == '0) && (!par_en || par_low) && stop1_low_n;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state            <= IDLE;
            tick_cnt         <= '0;
            bit_cnt          <= '0;
            shreg            <= '0;
            samp0            <= 1'b0;
            samp1            <= 1'b0;
            par_mode         <= PAR_NONE;
            two_stop         <= 1'b0;
            perr             <= 1'b0;
            ferr             <= 1'b0;
            par_low          <= 1'b0;
            stop1_low        <= 1'b0;
            bus.o_data       <= '0;
            bus.o_valid      <= 1'b0;
            bus.o_parity_err <= 1'b0;
            bus.o_frame_err  <= 1'b0;
            bus.o_break      <= 1'b0;
            bus.o_busy       <= 1'b0;
        end else begin
            bus.o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_pulse) begin
                        state      <= START;
                        bus.o_busy <= 1'b1;
                        tick_cnt   <= '0;
                        par_mode   <= bus.i_parity_mode;
                        two_stop   <= bus.i_two_stop;
                        perr       <= 1'b0;
                        ferr       <= 1'b0;
                        par_low    <= 1'b0;
                        stop1_low  <= 1'b0;
                    end
                end
                START: begin
                    if (bus.i_s_tick) begin
                        if (tick_cnt == TW'(TICKS/2-1)) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (rx_s) begin
                                state      <= IDLE;
                                bus.o_busy <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: begin
                    if (bus.i_s_tick) begin
                        if (tick_cnt == TW'(TICKS-3)) samp0 <= rx_s;
                        if (tick_cnt == TW'(TICKS-2)) samp1 <= rx_s;
                        if (bit_end) begin
                            tick_cnt <= '0;
                            case (state)
                                DATA: begin
                                    shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                                    bit_cnt <= bit_cnt + BW'(1);
                                    if (bit_cnt == BW'(DATA_BITS-1))
                                        state <= par_en ? PARITY : STOP1;
                                end
                                PARITY: begin
                                    perr    <= bit_val ^ (^shreg) ^ (par_mode == PAR_ODD);
                                    par_low <= ~bit_val;
                                    state   <= STOP1;
                                end
                                STOP1: begin
                                    ferr      <= ~bit_val;
                                    stop1_low <= ~bit_val;
                                    if (two_stop) state <= STOP2;
                                end
                                default: ;
                            endcase
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
            endcase

            if (finishing) begin
                state            <= IDLE;
                bus.o_busy       <= 1'b0;
                bus.o_valid      <= 1'b1;
                bus.o_data       <= shreg;
                bus.o_parity_err <= perr;
                bus.o_frame_err  <= ferr_n;
                bus.o_break      <= break_n;
            end
        end
    end

endmodule
